// File: rtl/fifo_stream_serializer.sv
// rtl/fifo_stream_serializer.sv - Serializes FWFT FIFO words into a lane-wide valid/ready stream
//
// Ports:
//   CLK           rising-edge clock
//   RESETn        synchronous active-low reset
//   Read_Request  start request, sampled in IDLE only
//   i_length      transfer length in lanes, sampled with Read_Request
//   i_FIFO_empty  FWFT FIFO empty flag
//   i_FIFO_dout   FWFT FIFO head word
//   o_FIFO_rd_en  FIFO pop strobe (combinational, one cycle per consumed word)
//   o_data        current output lane
//   o_valid       o_data valid
//   i_ready       downstream accept
//   o_last        final lane of the transfer
//   o_busy        high whenever the controller is not IDLE
//   o_done        one-cycle pulse after a transfer completes

module fifo_stream_serializer #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              Read_Request,
    input  logic [LEN_W-1:0]  i_length,
    input  logic              i_FIFO_empty,
    input  logic [DATA_W-1:0] i_FIFO_dout,
    output logic              o_FIFO_rd_en,
    output logic [LANE_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    generate
        if (LANES < 2 || (LANES & (LANES - 1)) != 0 || DATA_W != LANES * LANE_W) begin : g_bad_params
            $error("fifo_stream_serializer: DATA_W/LANE_W must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STREAM    = 2'd1,
        WAIT_FIFO = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   lane_idx_q, lane_idx_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               done_q, done_d;

    // Split the head word into lanes; lane 0 is the least significant slice.
    logic [LANE_W-1:0]  lane_words [LANES];

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign lane_words[g] = i_FIFO_dout[g*LANE_W +: LANE_W];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            lane_idx_q  <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_idx_q  <= lane_idx_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lane_idx_d   = lane_idx_q;
        remaining_d  = remaining_q;
        done_d       = 1'b0;
        o_valid      = 1'b0;
        o_data       = '0;
        o_last       = 1'b0;
        o_FIFO_rd_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (Read_Request) begin
                    if (i_length != '0) begin
                        remaining_d = i_length;
                        lane_idx_d  = '0;
                        state_d     = STREAM;
                    end else begin
                        // Zero-length request completes immediately without touching the FIFO.
                        done_d = 1'b1;
                    end
                end
            end

            STREAM: begin
                if (i_FIFO_empty) begin
                    state_d = WAIT_FIFO;
                end else begin
                    o_valid = 1'b1;
                    o_data  = lane_words[lane_idx_q];
                    o_last  = (remaining_q == LEN_W'(1));
                    if (i_ready) begin
                        lane_idx_d  = lane_idx_q + 1'b1;
                        remaining_d = (remaining_q != '0) ? remaining_q - 1'b1 : '0;
                        // Pop on the top lane, or on the final lane so a partially
                        // used word does not linger at the FIFO head.
                        o_FIFO_rd_en = (lane_idx_q == IDX_W'(LANES - 1)) || o_last;
                        if (o_last) begin
                            state_d    = IDLE;
                            lane_idx_d = '0;
                            done_d     = 1'b1;
                        end
                    end
                end
            end

            WAIT_FIFO: begin
                if (!i_FIFO_empty) begin
                    state_d = STREAM;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_busy = (state_q != IDLE);
    assign o_done = done_q;

endmodule
